adam_aes_key_expander: RTL and testbench

Sequential AES key schedule that sits directly upstream of the AES encipher round datapath. On an `init` pulse it expands a 128- or 256-bit cipher key into 11 or 15 round keys, one per cycle, and stores them in a register file. The cipher then reads them by round index through a combinational lookup. SubWord goes through a shared 32-bit S-box port by default; a local S-box is a compile option.

---
 rtl/adam_aes_key_expander_if.sv | 21 ++
 rtl/adam_aes_key_expander.sv | 136 +++++++++++++
 tb/tb_adam_aes_key_expander.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/adam_aes_key_expander_if.sv
// Key-expander bus: cipher-side control, round-key lookup and the shared S-box port.
interface adam_aes_key_expander_if;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;

  modport master (
    output init, key, keylen, round, new_sboxw,
    input  round_key, sboxw, ready
  );

  modport slave (
    input  init, key, keylen, round, new_sboxw,
    output round_key, sboxw, ready
  );
endinterface

// File: rtl/adam_aes_key_expander.sv
// Sequential AES-128/256 key schedule writing one round key per cycle into a 15-slot file.
// Define ADAM_AES_KEY_LOCAL_SBOX_EN to use a local S-box instead of the shared sboxw/new_sboxw port.
`ifdef ADAM_AES_KEY_LOCAL_SBOX_EN
module adam_aes_sbox_byte (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = '0;
    xx = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (8'h1b & {8{xx[7]}});
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine transform.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule
`endif

module adam_aes_key_expander (
  input  logic                    clk,
  input  logic                    reset_n,
  adam_aes_key_expander_if.slave  bus
);
  typedef enum logic {IDLE, GEN} state_t;

  state_t       state, state_nxt;
  logic [255:0] key_r;
  logic         keylen_r;
  logic [3:0]   ctr;
  logic [7:0]   rcon;
  logic [127:0] p_reg, q_reg;
  logic [127:0] mem [15];

  logic         accept, last, use_rcon, gen_word;
  logic [31:0]  s_word, t_word, w0, w1, w2, w3;
  logic [127:0] wdata;

  assign accept   = (state == IDLE) && bus.init;
  assign last     = (ctr == (keylen_r ? 4'd14 : 4'd10));
  assign use_rcon = !keylen_r || !ctr[0];
  assign gen_word = (ctr != 4'd0) && !(keylen_r && (ctr == 4'd1));

`ifdef ADAM_AES_KEY_LOCAL_SBOX_EN
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    adam_aes_sbox_byte u_sbox (.a(p_reg[8*b +: 8]), .s(s_word[8*b +: 8]));
  end
`else
  assign s_word = bus.new_sboxw;
`endif

  always_comb begin
    t_word = use_rcon ? ({s_word[23:0], s_word[31:24]} ^ {rcon, 24'h0}) : s_word;
    w0     = q_reg[127:96] ^ t_word;
    w1     = q_reg[95:64]  ^ w0;
    w2     = q_reg[63:32]  ^ w1;
    w3     = q_reg[31:0]   ^ w2;
    if (ctr == 4'd0)
      wdata = key_r[255:128];
    else if (!gen_word)
      wdata = key_r[127:0];
    else
      wdata = {w0, w1, w2, w3};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.init) state_nxt = GEN;
      GEN:  if (last)     state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == IDLE);
`ifdef ADAM_AES_KEY_LOCAL_SBOX_EN
    bus.sboxw = '0;
`else
    bus.sboxw = (state == GEN) ? p_reg[31:0] : '0;
`endif
    bus.round_key = (bus.round <= 4'd14) ? mem[bus.round] : '0;
  end

  // P/Q track the last two written slots; for AES-128 both hold the previous slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_r    <= '0;
      keylen_r <= 1'b0;
      ctr      <= '0;
      rcon     <= 8'h01;
      p_reg    <= '0;
      q_reg    <= '0;
      for (int unsigned i = 0; i < 15; i++) mem[i] <= '0;
    end else if (accept) begin
      key_r    <= bus.key;
      keylen_r <= bus.keylen;
      ctr      <= '0;
      rcon     <= 8'h01;
      p_reg    <= '0;
    end else if (state == GEN) begin
      mem[ctr] <= wdata;
      p_reg    <= wdata;
      q_reg    <= keylen_r ? p_reg : wdata;
      ctr      <= ctr + 4'd1;
      if (gen_word && use_rcon)
        rcon <= {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
    end
  end
endmodule

// File: tb/tb_adam_aes_key_expander.sv
// Directed bench for adam_aes_key_expander with a word-oriented reference key schedule.
module tb_adam_aes_key_expander;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_slot [15];

  localparam logic [255:0] K128  = 256'h2b7e151628aed2a6abf7158809cf4f3c_0123456789abcdeffedcba9876543210;
  localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  adam_aes_key_expander_if ifc ();

  adam_aes_key_expander dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  assign ifc.new_sboxw = {sbox_tab[ifc.sboxw[31:24]], sbox_tab[ifc.sboxw[23:16]],
                          sbox_tab[ifc.sboxw[15:8]],  sbox_tab[ifc.sboxw[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // FIPS-197 word-array expansion; slots beyond Nr are left untouched.
  task automatic model_expand(input logic [255:0] k, input logic kl);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = xt(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        temp = subw(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r <= nr; r++) exp_slot[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ifc.round = i[3:0];
      #1;
      check($sformatf("%s_rk%0d", tag, i), ifc.round_key, (i < 15) ? exp_slot[i] : 128'h0);
    end
  endtask

  task automatic rk_is(input string tag, input int idx, input logic [127:0] val);
    ifc.round = idx[3:0];
    #1;
    check(tag, ifc.round_key, val);
  endtask

  task automatic run_exp(input string tag, input logic [255:0] k, input logic kl,
                         input int repulse_at, input int abort_at);
    int j = 0;
    bit done = 0;
    bit aborted = 0;
    logic [31:0] exp_sw;
    model_expand(k, kl);
    ifc.key    = k;
    ifc.keylen = kl;
    ifc.init   = 1'b1;
    @(negedge clk);
    ifc.init = 1'b0;
    while (!done && j < 40) begin
      if (ifc.ready) begin
        done = 1;
      end else begin
        if (j >= 1) begin
`ifdef ADAM_AES_KEY_LOCAL_SBOX_EN
          exp_sw = '0;
`else
          exp_sw = exp_slot[j-1][31:0];
`endif
          check($sformatf("%s_sboxw%0d", tag, j), {96'h0, ifc.sboxw}, {96'h0, exp_sw});
        end
        if (j == repulse_at) begin
          ifc.init   = 1'b1;
          ifc.key    = ~k;
          ifc.keylen = ~kl;
        end else begin
          ifc.init = 1'b0;
        end
        if (j == abort_at) begin
          reset_n = 1'b0;
          @(negedge clk);
          reset_n = 1'b1;
          aborted = 1;
          done    = 1;
          check($sformatf("%s_abort_ready", tag), {127'h0, ifc.ready}, 128'h1);
          for (int s = 0; s < 15; s++) exp_slot[s] = '0;
        end else begin
          j++;
          @(negedge clk);
        end
      end
    end
    if (!aborted) begin
      check($sformatf("%s_low_cycles", tag), j, kl ? 128'd15 : 128'd11);
      check($sformatf("%s_idle_sboxw", tag), {96'h0, ifc.sboxw}, 128'h0);
    end
  endtask

  initial begin
    build_sbox();
    for (int s = 0; s < 15; s++) exp_slot[s] = '0;
    reset_n    = 1'b0;
    ifc.init   = 1'b0;
    ifc.key    = '0;
    ifc.keylen = 1'b0;
    ifc.round  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {127'h0, ifc.ready}, 128'h1);
    check("reset_sboxw", {96'h0, ifc.sboxw}, 128'h0);
    sweep("reset");

    run_exp("a128", K128, 1'b0, -1, -1);
    sweep("a128");
    rk_is("a128_r1",  1,  128'ha0fafe1788542cb123a339392a6c7605);
    rk_is("a128_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_exp("a256", K256, 1'b1, -1, -1);
    sweep("a256");
    rk_is("a256_r1",  1,  128'h1f352c073b6108d72d9810a30914dff4);
    rk_is("a256_r2",  2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    rk_is("a256_r14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

    run_exp("repulse", K128, 1'b0, 5, -1);
    rk_is("repulse_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep("repulse");

    run_exp("abort", K256, 1'b1, -1, 6);
    sweep("abort");

    run_exp("fresh", K128, 1'b0, -1, -1);
    rk_is("fresh_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_exp("b2b", K256, 1'b1, -1, -1);
    sweep("b2b");
    rk_is("b2b_r14", 14, 128'hfe4890d1e6188d0b046df344706c631e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
